// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - CPU bus, fetch engine and RAM port bundle for the framebuffer arbiter
`timescale 1ns/1ps

interface vga_fb_arbiter_if #(
  parameter int ADDR_WIDTH = 15
);
  // CPU data bus
  logic                  cs;
  logic [19:1]           data_m_addr;
  logic [15:0]           data_m_data_in;
  logic [15:0]           data_m_data_out;
  logic [1:0]            data_m_bytesel;
  logic                  data_m_wr_en;
  logic                  data_m_access;
  logic                  data_m_ack;
  // display fetch engine
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_urgent;
  logic                  fetch_grant;
  logic                  fetch_valid;
  logic [15:0]           fetch_data;
  // single-port framebuffer RAM
  logic                  mem_en;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [1:0]            mem_bytesel;
  logic [15:0]           mem_rdata;

  modport master (
    output cs, data_m_addr, data_m_data_in, data_m_bytesel, data_m_wr_en, data_m_access,
    output fetch_req, fetch_addr, fetch_urgent,
    output mem_rdata,
    input  data_m_data_out, data_m_ack,
    input  fetch_grant, fetch_valid, fetch_data,
    input  mem_en, mem_wr_en, mem_addr, mem_wdata, mem_bytesel
  );

  modport slave (
    input  cs, data_m_addr, data_m_data_in, data_m_bytesel, data_m_wr_en, data_m_access,
    input  fetch_req, fetch_addr, fetch_urgent,
    input  mem_rdata,
    output data_m_data_out, data_m_ack,
    output fetch_grant, fetch_valid, fetch_data,
    output mem_en, mem_wr_en, mem_addr, mem_wdata, mem_bytesel
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shares the single-port VGA framebuffer RAM between the CPU bus and display fetch
`timescale 1ns/1ps

module vga_fb_arbiter #(
  parameter int ADDR_WIDTH       = 15,
  parameter int MEM_LATENCY      = 2,
  parameter int CPU_STARVE_LIMIT = 8
) (
  input logic             clk,
  input logic             reset,
  vga_fb_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_MAX = 4'(CPU_STARVE_LIMIT);

  typedef enum logic [1:0] {
    CPU_IDLE,
    CPU_WAIT_GRANT,
    CPU_WAIT_DATA
  } cpu_state_t;

  cpu_state_t cpu_state;
  cpu_state_t cpu_state_next;

  logic       cpu_req;
  logic       cpu_pending;
  logic       cpu_grant;
  logic       fetch_win;
  logic [3:0] starve_cnt;
  logic [3:0] starve_cnt_next;

  logic                  mem_en_q;
  logic                  mem_wr_en_q;
  logic                  owner_cpu_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [15:0]           mem_wdata_q;
  logic [1:0]            mem_bytesel_q;

  logic [MEM_LATENCY-1:0] tag_valid;
  logic [MEM_LATENCY-1:0] tag_cpu;
  logic                   tail_valid;
  logic                   tail_cpu;

  logic        ack_q;
  logic [15:0] cpu_rdata_q;
  logic        fetch_valid_q;
  logic [15:0] fetch_data_q;

  // Upper CPU address bits beyond the framebuffer are deliberately dropped.
  if (ADDR_WIDTH < 19) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.data_m_addr[19:ADDR_WIDTH+1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_state  <= CPU_IDLE;
      starve_cnt <= '0;
    end else begin
      cpu_state  <= cpu_state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Arbitration, starvation counter and CPU FSM; grants are suppressed during reset.
  always_comb begin
    cpu_req         = bus.cs & bus.data_m_access & (cpu_state == CPU_IDLE) & ~ack_q;
    cpu_pending     = cpu_req | (cpu_state == CPU_WAIT_GRANT);
    fetch_win       = 1'b0;
    cpu_grant       = 1'b0;
    starve_cnt_next = starve_cnt;
    cpu_state_next  = cpu_state;

    if (!reset) begin
      if (bus.fetch_req && (!cpu_pending || (bus.fetch_urgent && (starve_cnt < STARVE_MAX)))) begin
        fetch_win = 1'b1;
      end else if (cpu_pending) begin
        cpu_grant = 1'b1;
      end
    end

    if (cpu_grant || !cpu_pending) begin
      starve_cnt_next = '0;
    end else if (fetch_win && (starve_cnt < STARVE_MAX)) begin
      starve_cnt_next = starve_cnt + 4'd1;
    end

    case (cpu_state)
      CPU_IDLE: begin
        if (cpu_grant) begin
          cpu_state_next = CPU_WAIT_DATA;
        end else if (cpu_req) begin
          cpu_state_next = CPU_WAIT_GRANT;
        end
      end
      CPU_WAIT_GRANT: begin
        if (cpu_grant) begin
          cpu_state_next = CPU_WAIT_DATA;
        end
      end
      CPU_WAIT_DATA: begin
        if (ack_q) begin
          cpu_state_next = CPU_IDLE;
        end
      end
      default: cpu_state_next = CPU_IDLE;
    endcase
  end

  // Issue stage: one RAM operation per cycle; address/data/bytesel hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en_q      <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      owner_cpu_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_bytesel_q <= '0;
    end else begin
      mem_en_q    <= fetch_win | cpu_grant;
      mem_wr_en_q <= cpu_grant & bus.data_m_wr_en;
      owner_cpu_q <= cpu_grant;
      if (cpu_grant) begin
        mem_addr_q    <= bus.data_m_addr[ADDR_WIDTH:1];
        mem_wdata_q   <= bus.data_m_data_in;
        mem_bytesel_q <= bus.data_m_bytesel;
      end else if (fetch_win) begin
        mem_addr_q <= bus.fetch_addr;
      end
    end
  end

  // Tags enter one cycle after mem_en so the tail lines up with valid mem_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      tag_cpu   <= '0;
    end else begin
      tag_valid[0] <= mem_en_q & ~mem_wr_en_q;
      tag_cpu[0]   <= owner_cpu_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_cpu[i]   <= tag_cpu[i-1];
      end
    end
  end

  assign tail_valid = tag_valid[MEM_LATENCY-1];
  assign tail_cpu   = tag_cpu[MEM_LATENCY-1];

  // Return routing; CPU writes ack straight off the issue stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q         <= 1'b0;
      cpu_rdata_q   <= '0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      ack_q         <= (tail_valid & tail_cpu) | (mem_en_q & mem_wr_en_q);
      cpu_rdata_q   <= (tail_valid & tail_cpu) ? bus.mem_rdata : 16'h0000;
      fetch_valid_q <= tail_valid & ~tail_cpu;
      if (tail_valid && !tail_cpu) begin
        fetch_data_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.fetch_grant     = fetch_win;
  assign bus.fetch_valid     = fetch_valid_q;
  assign bus.fetch_data      = fetch_data_q;
  assign bus.data_m_ack      = ack_q;
  assign bus.data_m_data_out = cpu_rdata_q;
  assign bus.mem_en          = mem_en_q;
  assign bus.mem_wr_en       = mem_wr_en_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_bytesel     = mem_bytesel_q;

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares the single-port VGA framebuffer RAM between two requesters: the CPU data bus (`data_m_*`, chip-select decoded upstream) and the display fetch engine that streams pixel/character words to the VGA pipeline. It issues at most one RAM operation per `clk` cycle and tracks in-flight reads through a fixed-latency tag pipeline. It routes returned data to the correct requester. While a line is active, display fetches take priority, and a starvation limit guarantees forward progress for the CPU.

## Interface
Parameters:
- `ADDR_WIDTH`, default 15: framebuffer word-address width.
- `MEM_LATENCY`, default 2: cycles from `mem_en` to valid `mem_rdata`. Legal range is 1..4.
- `CPU_STARVE_LIMIT`, default 8: maximum consecutive fetch grants while a CPU request is waiting. Legal range is 1..15.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high. Clock is `clk`.
- `cs` in 1: framebuffer chip select.
- `data_m_addr` in 19 (`[19:1]`): CPU word address. Only `[ADDR_WIDTH:1]` is used.
- `data_m_data_in` in 16: CPU write data.
- `data_m_data_out` out 16: CPU read data. Valid only while `data_m_ack` is high, otherwise 0.
- `data_m_bytesel` in 2: byte enables.
- `data_m_wr_en` in 1: 1 means write, 0 means read.
- `data_m_access` in 1: CPU access request. Held until ack.
- `data_m_ack` out 1: single-cycle completion pulse.
- `fetch_req` in 1: fetch engine request.
- `fetch_addr` in ADDR_WIDTH: fetch word address.
- `fetch_urgent` in 1: the display is in the active region and fetches have priority.
- `fetch_grant` out 1: combinational. `fetch_addr` is consumed at the end of this cycle.
- `fetch_valid` out 1: pulse indicating `fetch_data` is valid.
- `fetch_data` out 16: fetched word.
- `mem_en` out 1: RAM operation strobe.
- `mem_wr_en` out 1: RAM write.
- `mem_addr` out ADDR_WIDTH: RAM address.
- `mem_wdata` out 16: RAM write data.
- `mem_bytesel` out 2: RAM byte enables.
- `mem_rdata` in 16: RAM read data.

## Operation
- **CPU request.** `cpu_req = cs & data_m_access & (cpu_state == IDLE) & ~data_m_ack`.
- **CPU FSM:**
  - IDLE moves to WAIT_GRANT on `cpu_req` if the request is not granted in the same cycle.
  - IDLE or WAIT_GRANT moves to WAIT_DATA when granted.
  - WAIT_DATA moves to IDLE in the cycle `data_m_ack` is pulsed.
  - Only one CPU transaction is outstanding at a time.
- **Arbitration** is combinational each cycle, among `cpu_pending = cpu_req | (cpu_state == WAIT_GRANT)` and `fetch_req`:
  - If only one requester is active, it wins.
  - If both are active and `fetch_urgent` is high and `starve_cnt < CPU_STARVE_LIMIT`, fetch wins. Otherwise CPU wins.
- **`starve_cnt` (4 bit):**
  - Increments on each fetch grant while `cpu_pending`.
  - Clears on a CPU grant, or in any cycle with `~cpu_pending`.
  - Saturates at `CPU_STARVE_LIMIT`.
- **Issue.** The winner's operation is registered onto the `mem_*` outputs for exactly one cycle with `mem_en` high.
  - Fetch operations are always reads.
  - CPU operations carry address, wdata, bytesel and wr_en from the bus.
  - When no operation is issued, `mem_en` and `mem_wr_en` are 0. `mem_addr`, `mem_wdata` and `mem_bytesel` hold their last value.
- **Tag pipeline.** A shift register of depth `MEM_LATENCY` holds `{valid, owner}` for each read issued. At the tail, the owner determines whether `mem_rdata` is registered into `fetch_data`/`fetch_valid` or into `data_m_data_out`/`data_m_ack`.
- **CPU writes** ack in the cycle after `mem_en`. They need no tag.
- **Fetch throughput** is one word per cycle with no bubbles while uncontended.
- **Reset** takes effect immediately:
  - Clears the FSM, `starve_cnt` and tags.
  - All outputs go to 0.
  - In-flight read data is discarded. No ack and no `fetch_valid` is produced for operations issued before reset.

## Timing
The CPU request is first high in cycle T. With no contention:
- `mem_en` is high in T+1.
- A write acks in T+2.
- A read acks in T+2+MEM_LATENCY (T+4 at default), with `data_m_data_out` valid in the same cycle.

A fetch request granted in cycle G:
- `mem_en` is high in G+1.
- `fetch_valid` is high in G+2+MEM_LATENCY.
- `fetch_valid` pulses appear in grant order.

Boundary conditions:
- **Simultaneous CPU ack and fetch return:** impossible, since tails are one per cycle. A CPU read and a fetch never share a tail slot.
- **Access held high in the ack cycle:** the access is not re-requested (`~data_m_ack` term). A new access is recognised from the cycle after ack.
- **`fetch_urgent` falling while the CPU waits:** the CPU wins the next contended cycle regardless of `starve_cnt`.
- **Address truncation:** `data_m_addr` bits above ADDR_WIDTH are ignored. There is no error and no wrap detection.

## Test plan
- **CPU write then read, idle fetch.** Write 0xA55A to address 0x0010 with bytesel 2'b11. Require ack at T+2 and `mem_en` exactly once. Read address 0x0010: ack at T+4 with data_out 0xA55A.
- **Pipelined fetch burst.** Hold `fetch_req` for 8 cycles at addresses 0x100..0x107 with RAM model word = address. Require 8 consecutive `fetch_grant`, and 8 consecutive `fetch_valid` with data 0x100..0x107 starting 4 cycles after the first grant.
- **Starvation limit.** `fetch_urgent=1`, continuous fetch, CPU read at cycle 5. Require exactly 8 fetch grants, then a CPU grant, then fetch resumes. The CPU ack carries the correct data, and the fetch data order is intact.
- **Non-urgent priority.** `fetch_urgent=0` with CPU and fetch requesting in the same cycle. Require the CPU granted first, the fetch granted the next cycle, and `starve_cnt` staying 0.
- **Reset mid-read.** Issue a CPU read and 2 fetches, then assert reset in the cycle after `mem_en`. Require all outputs 0 immediately, no ack and no `fetch_valid` after release, and a fresh CPU read completing normally.
- **Byte write.** Write bytesel 2'b10 with data 0x3300 over existing 0x1122. Require `mem_bytesel=2'b10`, and a later read returning 0x3322.
